// File: rtl/oqpsk_stream_ctrl.sv
// Byte-stream front end for an OQPSK modulator: buffers bytes, serialises them MSB first
// onto mod_bit, paces sample requests, and captures the returned I/Q samples.
module oqpsk_stream_ctrl #(
   parameter int SAMPLE_DIV = 16,
   parameter int SPB        = 8,
   parameter int CAP_LAT    = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start,
   input  logic [7:0]  din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        mod_en,
   output logic        mod_bit,
   output logic        mod_req_sample,
   output logic        mod_ack,
   input  logic [12:0] mod_i,
   input  logic [12:0] mod_q,
   output logic [12:0] smp_i,
   output logic [12:0] smp_q,
   output logic        smp_valid,
   input  logic        smp_ready,
   output logic        busy,
   output logic        underrun,
   output logic        overrun,
   input  logic        clr_flags
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_t;
   state_t state, state_n;

   localparam logic [7:0] T_LAST = 8'(SAMPLE_DIV - 1);
   localparam logic [7:0] T_CAP  = 8'(CAP_LAT);
   localparam logic [6:0] R_LAST = 7'(SPB - 1);

   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count, count_n;
   logic       fifo_empty, push, pop;
   logic [7:0] timer;
   logic [6:0] req_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       bit_end, capture, underrun_set, overrun_set;

   assign fifo_empty  = (count == 3'd0);
   assign push        = din_valid && din_ready;
   assign count_n     = count + {2'b00, push} - {2'b00, pop};
   assign bit_end     = (state == RUN) && (timer == T_LAST) && (req_cnt == R_LAST);
   assign capture     = (state == RUN) && (timer == T_CAP);
   assign overrun_set = capture && smp_valid && !smp_ready;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n      = state;
      pop          = 1'b0;
      underrun_set = 1'b0;
      case (state)
         IDLE: if (start && !fifo_empty) state_n = LOAD;
         LOAD: begin
            pop     = 1'b1;
            state_n = RUN;
         end
         RUN: begin
            // Byte boundary: chain the next byte with no gap, otherwise wind down.
            if (bit_end && bit_idx == 3'd0) begin
               if (start && !fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_n      = STOP;
                  underrun_set = start;
               end
            end
         end
         STOP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) fifo_mem[wr_ptr] <= din;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr         <= 2'd0;
         rd_ptr         <= 2'd0;
         count          <= 3'd0;
         din_ready      <= 1'b1;
         mod_en         <= 1'b0;
         busy           <= 1'b0;
         mod_req_sample <= 1'b0;
         mod_ack        <= 1'b0;
         mod_bit        <= 1'b0;
         timer          <= 8'd0;
         req_cnt        <= 7'd0;
         bit_idx        <= 3'd0;
         shreg          <= 8'd0;
         smp_i          <= 13'd0;
         smp_q          <= 13'd0;
         smp_valid      <= 1'b0;
         underrun       <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         count     <= count_n;
         din_ready <= (count_n != 3'd4);

         mod_en  <= (state_n == RUN);
         busy    <= (state_n != IDLE);
         // Request is high exactly in the RUN cycles where the timer reads 0.
         mod_req_sample <= (state == LOAD) ||
                           ((state == RUN) && (timer == T_LAST) && (state_n == RUN));
         mod_ack <= capture;

         if (state == LOAD) begin
            timer   <= 8'd0;
            req_cnt <= 7'd0;
         end else if (state == RUN) begin
            if (timer == T_LAST) begin
               timer   <= 8'd0;
               req_cnt <= (req_cnt == R_LAST) ? 7'd0 : req_cnt + 7'd1;
            end else begin
               timer <= timer + 8'd1;
            end
         end

         if (pop) begin
            shreg   <= fifo_mem[rd_ptr];
            mod_bit <= fifo_mem[rd_ptr][7];
            bit_idx <= 3'd7;
         end else if (bit_end && bit_idx != 3'd0) begin
            shreg   <= {shreg[6:0], 1'b0};
            mod_bit <= shreg[6];
            bit_idx <= bit_idx - 3'd1;
         end

         // The capture edge closes the timer == CAP_LAT cycle; a fresh capture beats a drain.
         if (capture) begin
            smp_i     <= mod_i;
            smp_q     <= mod_q;
            smp_valid <= 1'b1;
         end else if (smp_valid && smp_ready) begin
            smp_valid <= 1'b0;
         end

         if (underrun_set)   underrun <= 1'b1;
         else if (clr_flags) underrun <= 1'b0;
         if (overrun_set)    overrun  <= 1'b1;
         else if (clr_flags) overrun  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_oqpsk_stream_ctrl.sv
// Directed bench for oqpsk_stream_ctrl: serialisation, byte chaining, capture/overrun,
// FIFO back-pressure, mid-byte stop and asynchronous reset.
module tb_oqpsk_stream_ctrl;
   localparam int SAMPLE_DIV = 16;
   localparam int SPB        = 8;
   localparam int CAP_LAT    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  din = 8'd0;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic        mod_en, mod_bit, mod_req_sample, mod_ack;
   logic [12:0] mod_i = 13'h0123;
   logic [12:0] mod_q = 13'h0456;
   logic [12:0] smp_i, smp_q;
   logic        smp_valid;
   logic        smp_ready = 1'b1;
   logic        busy, underrun, overrun;
   logic        clr_flags = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   logic exp_q[$];

   oqpsk_stream_ctrl #(
      .SAMPLE_DIV(SAMPLE_DIV), .SPB(SPB), .CAP_LAT(CAP_LAT)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .mod_en(mod_en), .mod_bit(mod_bit), .mod_req_sample(mod_req_sample), .mod_ack(mod_ack),
      .mod_i(mod_i), .mod_q(mod_q),
      .smp_i(smp_i), .smp_q(smp_q), .smp_valid(smp_valid), .smp_ready(smp_ready),
      .busy(busy), .underrun(underrun), .overrun(overrun), .clr_flags(clr_flags)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      start = 1'b0; din_valid = 1'b0; clr_flags = 1'b0; smp_ready = 1'b1;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic push_byte(input logic [7:0] b);
      din = b; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
   endtask

   task automatic queue_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--)
         for (int k = 0; k < SPB; k++) exp_q.push_back(b[i]);
   endtask

   // Watches one run from busy rising to busy falling, checking mod_bit at each request.
   task automatic watch_run(input int drop_at, output int reqs, output int en_cyc,
                            output int en_rise, output int stop_cyc, output int gap_bad);
      int cyc, last_req;
      logic prev_en, seen_en;
      reqs = 0; en_cyc = 0; en_rise = 0; stop_cyc = 0; gap_bad = 0;
      cyc = 0;
      while (!busy && cyc < 50) begin tick(); cyc++; end
      check_eq("busy_rise", busy, 1);
      cyc = 0; last_req = -1; prev_en = 1'b0; seen_en = 1'b0;
      while (busy && cyc < 5000) begin
         if (cyc == drop_at) start = 1'b0;
         if (mod_req_sample) begin
            if (last_req >= 0 && (cyc - last_req) != SAMPLE_DIV) gap_bad++;
            last_req = cyc;
            reqs++;
            if (exp_q.size() > 0) check_eq("mod_bit", mod_bit, exp_q.pop_front());
            else                  check_eq("extra_req", 1, 0);
         end
         if (mod_en) en_cyc++;
         if (mod_en && !prev_en) en_rise++;
         if (!mod_en && seen_en) stop_cyc++;
         if (mod_en) seen_en = 1'b1;
         prev_en = mod_en;
         tick();
         cyc++;
      end
      check_eq("run_ends", busy, 0);
   endtask

   int reqs, en_cyc, en_rise, stop_cyc, gap_bad, cyc;

   initial begin
      // Reset values while reset is held.
      tick();
      check_eq("rst_din_ready", din_ready, 1);
      check_eq("rst_mod_en", mod_en, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_smp_valid", smp_valid, 0);
      check_eq("rst_flags", {underrun, overrun}, 0);
      do_reset();

      // Single byte 0xA5, start held: 64 requests, then underrun and STOP.
      push_byte(8'hA5);
      queue_bits(8'hA5);
      start = 1'b1;
      watch_run(-1, reqs, en_cyc, en_rise, stop_cyc, gap_bad);
      check_eq("a5_reqs", reqs, 64);
      check_eq("a5_gap", gap_bad, 0);
      check_eq("a5_en_cycles", en_cyc, 1024);
      check_eq("a5_stop_cycles", stop_cyc, 1);
      check_eq("a5_underrun", underrun, 1);
      check_eq("a5_exp_left", exp_q.size(), 0);
      exp_q.delete();
      do_reset();

      // Three bytes back-to-back: one continuous mod_en window.
      push_byte(8'hFF); push_byte(8'h00); push_byte(8'h3C);
      queue_bits(8'hFF); queue_bits(8'h00); queue_bits(8'h3C);
      start = 1'b1;
      watch_run(-1, reqs, en_cyc, en_rise, stop_cyc, gap_bad);
      check_eq("chain_reqs", reqs, 192);
      check_eq("chain_gap", gap_bad, 0);
      check_eq("chain_en_cycles", en_cyc, 3072);
      check_eq("chain_en_rises", en_rise, 1);
      check_eq("chain_stop_cycles", stop_cyc, 1);
      check_eq("chain_underrun", underrun, 1);
      exp_q.delete();
      do_reset();

      // Capture, overrun, clear, drain, then asynchronous reset mid-run.
      mod_i = 13'h0ABC; mod_q = 13'h1FFF; smp_ready = 1'b0;
      push_byte(8'h5A);
      start = 1'b1;
      cyc = 0;
      while (!mod_req_sample && cyc < 20) begin tick(); cyc++; end
      check_eq("cap_req_seen", mod_req_sample, 1);
      tick(); tick();
      check_eq("cap_early_ack", mod_ack, 0);
      check_eq("cap_early_valid", smp_valid, 0);
      tick();
      check_eq("cap_ack", mod_ack, 1);
      check_eq("cap_valid", smp_valid, 1);
      check_eq("cap_smp_i", smp_i, 13'h0ABC);
      check_eq("cap_smp_q", smp_q, 13'h1FFF);
      check_eq("cap_no_overrun", overrun, 0);
      tick();
      check_eq("cap_ack_pulse", mod_ack, 0);
      repeat (15) tick();
      check_eq("ovr_ack", mod_ack, 1);
      check_eq("ovr_set", overrun, 1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check_eq("ovr_clear", overrun, 0);
      smp_ready = 1'b1;
      tick();
      check_eq("smp_drain", smp_valid, 0);
      check_eq("mid_run_en", mod_en, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_mod_en", mod_en, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_din_ready", din_ready, 1);
      check_eq("arst_outs", {mod_bit, mod_req_sample, mod_ack, smp_valid, underrun, overrun}, 0);
      check_eq("arst_smp", {smp_i, smp_q}, 0);
      start = 1'b0;
      tick(); tick();
      rst = 1'b0;
      repeat (3) tick();
      check_eq("arst_no_stop", {busy, mod_en, underrun}, 0);
      mod_i = 13'h0123; mod_q = 13'h0456;
      do_reset();

      // FIFO fill with start low, then back-pressure release after LOAD.
      push_byte(8'h81); push_byte(8'h42); push_byte(8'h24);
      check_eq("fill3_ready", din_ready, 1);
      push_byte(8'h18);
      check_eq("fill4_ready", din_ready, 0);
      start = 1'b1;
      tick();
      check_eq("load_busy", busy, 1);
      check_eq("load_ready", din_ready, 0);
      check_eq("load_en", mod_en, 0);
      tick();
      check_eq("run_ready", din_ready, 1);
      check_eq("run_en", mod_en, 1);

      // Drop start mid-byte: 0x81 finishes, remaining bytes stay queued.
      queue_bits(8'h81);
      watch_run(400, reqs, en_cyc, en_rise, stop_cyc, gap_bad);
      check_eq("drop_reqs", reqs, 64);
      check_eq("drop_en_cycles", en_cyc, 1024);
      check_eq("drop_stop_cycles", stop_cyc, 1);
      check_eq("drop_underrun", underrun, 0);
      check_eq("drop_ready", din_ready, 1);
      queue_bits(8'h42); queue_bits(8'h24); queue_bits(8'h18);
      start = 1'b1;
      watch_run(-1, reqs, en_cyc, en_rise, stop_cyc, gap_bad);
      check_eq("rest_reqs", reqs, 192);
      check_eq("rest_gap", gap_bad, 0);
      check_eq("rest_en_cycles", en_cyc, 3072);
      check_eq("rest_underrun", underrun, 1);
      exp_q.delete();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
